// File: rtl/fifo_dist_pkg.sv
// Shared definitions for the fifo_distributor ingress writer: occupancy
// state encodings, default destination field position and destination decode.
package fifo_dist_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam int DEST_LSB_DEF = 8;
  localparam int NUM_DEST     = 4;

  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [1:0] dest);
    logic [NUM_DEST-1:0] oh;
    oh       = '0;
    oh[dest] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/fifo_dist_skid.sv
// Two-entry in-order word buffer with an EMPTY/ONE/TWO occupancy FSM.
// in_ready is registered from the next occupancy, so it never sees downstream flags.
module fifo_dist_skid
  import fifo_dist_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] head,
  output occ_t              occupancy,
  output logic              in_ready
);

  occ_t              state_q, state_next;
  logic [DATA_W-1:0] head_q, head_next;
  logic [DATA_W-1:0] tail_q, tail_next;
  logic              accept;
  logic              drain;

  // A write is only honoured while ready; a read needs something to read.
  assign accept = wr_en & in_ready;
  assign drain  = rd_en & (state_q != EMPTY);

  always_comb begin
    state_next = state_q;
    head_next  = head_q;
    tail_next  = tail_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_next  = wr_data;
          state_next = ONE;
        end
      end
      ONE: begin
        case ({accept, drain})
          2'b11: head_next = wr_data;
          2'b10: begin
            tail_next  = wr_data;
            state_next = TWO;
          end
          2'b01: state_next = EMPTY;
          default: state_next = ONE;
        endcase
      end
      TWO: begin
        // Tail moves up to head so the oldest word always sits in head.
        if (drain) begin
          head_next  = tail_q;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_next;
      head_q   <= head_next;
      tail_q   <= tail_next;
      in_ready <= (state_next != TWO);
    end
  end

  assign head      = head_q;
  assign occupancy = state_q;

endmodule

// File: rtl/fifo_distributor.sv
// Ingress writer: buffers the word stream and pushes each word, in order, to the
// input FIFO named by its destination field. Optional counters: FIFO_DIST_STATS_EN.
module fifo_distributor
  import fifo_dist_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int DEST_LSB = DEST_LSB_DEF
`ifdef FIFO_DIST_STATS_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              almost_full_P0,
  input  logic              almost_full_P1,
  input  logic              almost_full_P2,
  input  logic              almost_full_P3,
  output logic              push_F0,
  output logic              push_F1,
  output logic              push_F2,
  output logic              push_F3,
  output logic [DATA_W-1:0] data_out,
  output logic              idle
`ifdef FIFO_DIST_STATS_EN
  ,
  output logic [CNT_W-1:0]  push_cnt_0,
  output logic [CNT_W-1:0]  push_cnt_1,
  output logic [CNT_W-1:0]  push_cnt_2,
  output logic [CNT_W-1:0]  push_cnt_3,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  logic [DATA_W-1:0] head;
  occ_t              occupancy;
  logic [1:0]        dest;
  logic [3:0]        af_vec;
  logic              accept;
  logic              eligible;
  logic              next_empty;
  logic [3:0]        push_q;

  assign dest     = head[DEST_LSB +: 2];
  assign af_vec   = {almost_full_P3, almost_full_P2, almost_full_P1, almost_full_P0};
  assign accept   = in_valid & in_ready;
  // Only the head's own FIFO matters; the tail waits behind it regardless.
  assign eligible = (occupancy != EMPTY) && !af_vec[dest];

  // Mirrors the buffer's next occupancy so idle is registered alongside it.
  assign next_empty = ((occupancy == EMPTY) && !accept) ||
                      ((occupancy == ONE) && eligible && !accept);

  fifo_dist_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (in_valid),
    .wr_data   (in_data),
    .rd_en     (eligible),
    .head      (head),
    .occupancy (occupancy),
    .in_ready  (in_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      push_q   <= '0;
      data_out <= '0;
      idle     <= 1'b1;
    end else begin
      push_q <= eligible ? dest_onehot(dest) : 4'b0000;
      if (eligible) begin
        data_out <= head;
      end
      idle <= next_empty;
    end
  end

  assign push_F0 = push_q[0];
  assign push_F1 = push_q[1];
  assign push_F2 = push_q[2];
  assign push_F3 = push_q[3];

`ifdef FIFO_DIST_STATS_EN
  logic [CNT_W-1:0] push_cnt [NUM_DEST];

  // Saturating counters: pushes per destination and cycles a held word could not leave.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DEST; i++) begin
        push_cnt[i] <= '0;
      end
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_DEST; i++) begin
        if (eligible && (dest == 2'(i)) && (push_cnt[i] != '1)) begin
          push_cnt[i] <= push_cnt[i] + CNT_W'(1);
        end
      end
      if ((occupancy != EMPTY) && !eligible && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign push_cnt_0 = push_cnt[0];
  assign push_cnt_1 = push_cnt[1];
  assign push_cnt_2 = push_cnt[2];
  assign push_cnt_3 = push_cnt[3];
`endif

endmodule
